// File: rtl/rv0_issue_sb.sv
// Issue scoreboard: tracks outstanding integer/FP register writes and gates the
// decode-to-skid-buffer handshake on RAW/WAW hazards and serialising instructions.
module rv0_issue_sb #(
  parameter int unsigned NXREG  = 32,
  parameter int unsigned NFREG  = 32,
  parameter int unsigned RIDX_W = 5,
  parameter int unsigned PCNT_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              dec_rdy_i,
  output logic              dec_ack_o,
  input  logic [RIDX_W-1:0] dec_rs1_i,
  input  logic [RIDX_W-1:0] dec_rs2_i,
  input  logic [RIDX_W-1:0] dec_rs3_i,
  input  logic [2:0]        dec_rs_vld_i,
  input  logic [2:0]        dec_rs_fp_i,
  input  logic              dec_rd_vld_i,
  input  logic [RIDX_W-1:0] dec_rd_i,
  input  logic              dec_rd_fp_i,
  input  logic              dec_serial_i,
  output logic              sb_rdy_o,
  input  logic              sb_ack_i,
  input  logic              wb_vld_i,
  input  logic [RIDX_W-1:0] wb_rd_i,
  input  logic              wb_fp_i,
  output logic              idle_o,
  output logic [PCNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HAZ   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [NXREG-1:0] xbusy_q, xbusy_d, xeff, xclr, xset;
  logic [NFREG-1:0] fbusy_q, fbusy_d, feff, fclr, fset;
  logic [PCNT_W-1:0] cnt_q, cnt_d;

  logic [RIDX_W-1:0] rs_idx [3];
  logic src_hit, rd_hit, hazard, drain_blk, any_eff;
  logic issue_rdy, fire, stall_inc;

  assign rs_idx[0] = dec_rs1_i;
  assign rs_idx[1] = dec_rs2_i;
  assign rs_idx[2] = dec_rs3_i;

  // Writeback clear masks; effective busy lets a same-cycle writeback bypass
  always_comb begin
    xclr = '0;
    fclr = '0;
    if (wb_vld_i) begin
      if (wb_fp_i) fclr = NFREG'(1) << wb_rd_i;
      else         xclr = NXREG'(1) << wb_rd_i;
    end
    xeff    = xbusy_q & ~xclr;
    feff    = fbusy_q & ~fclr;
    xeff[0] = 1'b0;
    any_eff = (|xeff) | (|feff);
  end

  // Hazard detection over sources and destination
  always_comb begin
    src_hit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (dec_rs_vld_i[i]) begin
        src_hit = src_hit | (dec_rs_fp_i[i] ? feff[rs_idx[i]] : xeff[rs_idx[i]]);
      end
    end
    rd_hit    = dec_rd_vld_i & (dec_rd_fp_i ? feff[dec_rd_i] : xeff[dec_rd_i]);
    hazard    = dec_rdy_i & (src_hit | rd_hit);
    drain_blk = dec_serial_i & any_eff;
    issue_rdy = dec_rdy_i & ~hazard & ~drain_blk & ~flush_i;
    fire      = issue_rdy & sb_ack_i;
    stall_inc = dec_rdy_i & ~flush_i & (hazard | drain_blk);
  end

  // Busy update: set after clear so a new writer wins over a retiring one
  always_comb begin
    xset = '0;
    fset = '0;
    if (fire && dec_rd_vld_i) begin
      if (dec_rd_fp_i) fset = NFREG'(1) << dec_rd_i;
      else             xset = NXREG'(1) << dec_rd_i;
    end
    if (flush_i) begin
      xbusy_d = '0;
      fbusy_d = '0;
    end else begin
      xbusy_d = (xbusy_q & ~xclr) | xset;
      fbusy_d = (fbusy_q & ~fclr) | fset;
    end
    xbusy_d[0] = 1'b0;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall_inc && (cnt_q != {PCNT_W{1'b1}})) cnt_d = cnt_q + PCNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      xbusy_q <= '0;
      fbusy_q <= '0;
      cnt_q   <= '0;
    end else begin
      xbusy_q <= xbusy_d;
      fbusy_q <= fbusy_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_RUN;
    else         state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = ST_RUN;
    if (flush_i)                     state_d = ST_RUN;
    else if (dec_rdy_i && drain_blk) state_d = ST_DRAIN;
    else if (dec_rdy_i && hazard)    state_d = ST_HAZ;
  end

  // FSM outputs; handshake is combinational, idle is a view of registered state
  always_comb begin
    sb_rdy_o    = issue_rdy;
    dec_ack_o   = fire;
    idle_o      = (state_q == ST_RUN) & ~(|xbusy_q) & ~(|fbusy_q);
    stall_cnt_o = cnt_q;
  end

endmodule

// File: doc/rv0_issue_sb.md
Name: rv0_issue_sb

Overview:
Issue scoreboard and stall controller between decode and the execute-stage skid buffer. It tracks pending integer and FP register writes and gates the decode→skid-buffer rdy/ack handshake on RAW and WAW hazards. It also serialises instructions that must issue into an empty pipeline (CSR, FENCE). Writeback clears pending bits; flush resets all tracking state.

Parameters:
NXREG, 32, number of integer registers (x0 never tracked)
NFREG, 32, number of FP registers
RIDX_W, 5, register index width, equal to $clog2(max(NXREG,NFREG))
PCNT_W, 32, width of the stall performance counter

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  pipeline flush; clears scoreboard, blocks issue this cycle
dec_rdy_i  in  1  decode has a valid instruction
dec_ack_o  out  1  instruction accepted (issue fire)
dec_rs1_i  in  RIDX_W  source 1 index
dec_rs2_i  in  RIDX_W  source 2 index
dec_rs3_i  in  RIDX_W  source 3 index (FP fused ops)
dec_rs_vld_i  in  3  per-source valid {rs3,rs2,rs1}
dec_rs_fp_i  in  3  per-source FP flag (1=FP file)
dec_rd_vld_i  in  1  instruction writes rd
dec_rd_i  in  RIDX_W  destination index
dec_rd_fp_i  in  1  rd is FP
dec_serial_i  in  1  instruction must issue with scoreboard empty
sb_rdy_o  out  1  rdy into skid buffer
sb_ack_i  in  1  ack from skid buffer
wb_vld_i  in  1  writeback retiring a register write
wb_rd_i  in  RIDX_W  writeback index
wb_fp_i  in  1  writeback targets FP file
idle_o  out  1  no pending writes, state RUN
stall_cnt_o  out  PCNT_W  cycles dec_rdy_i held off by hazard or drain

Behaviour:
- State: xbusy[NXREG-1:1], fbusy[NFREG-1:0], FSM {RUN, HAZ, DRAIN}, stall counter. Reset: busy all 0, state RUN, stall_cnt_o=0.
- Effective busy eff = busy & ~wb_clear. Same-cycle writeback bypasses the clear, so it does not stall.
- hazard = dec_rdy_i & (any valid rs with eff[rs] in its file, or dec_rd_vld_i & eff[rd] in its file).
- Index 0 in the integer file is never busy. Integer rd=0 never sets a bit.
- drain_blk = dec_serial_i & (any eff bit set).
- sb_rdy_o = dec_rdy_i & ~hazard & ~drain_blk & ~flush_i. This is combinational, with no added latency.
- dec_ack_o = sb_rdy_o & sb_ack_i. This is the issue fire.
- On issue fire with dec_rd_vld_i, the busy bit for rd is set at the next edge.
- On wb_vld_i, the busy bit for wb_rd_i is cleared at the next edge.
- Same register set and cleared in the same cycle: set wins, because the new writer is outstanding.
- wb_vld_i to a non-busy register is ignored. Busy is 1-bit, so WAW guarantees a single outstanding writer.
- FSM, evaluated each cycle, next state:
  - flush_i → RUN
  - else dec_rdy_i & drain_blk → DRAIN
  - else dec_rdy_i & hazard → HAZ
  - else → RUN
- stall_cnt_o increments by 1 each cycle in which dec_rdy_i=1, not flushed, and (hazard | drain_blk). It saturates at all-ones.
- idle_o = (state==RUN) & no busy bits (registered view).
- flush_i: all busy bits cleared at the next edge, including any set requested in the same cycle. sb_rdy_o=0 that cycle. Writebacks in the flush cycle are ignored.
- Reset mid-operation: all state returns to reset values immediately (asynchronous).
- Handshake rule: dec_* inputs are held stable by decode while dec_rdy_i=1 and dec_ack_o=0. A stall caused by sb_ack_i=0 alone is not counted as a hazard stall.

Test Plan:
- Reset: after rst_ni deassert, apply dec_rdy_i=1, rs1=5, sb_ack_i=1 → sb_rdy_o=1, dec_ack_o=1, stall_cnt_o=0, idle_o=1.
- RAW integer: issue rd=x7; next cycle rs1=x7 → sb_rdy_o=0, state HAZ, stall_cnt_o counts 3 over 3 cycles. wb_vld_i rd=7 (int) in cycle 4 → issues that same cycle via bypass.
- File separation and x0: issue rd=f7 (FP); next instruction int rs1=x7 → no stall. Issue rd=x0 then rs1=x0 → no stall, idle_o stays 1.
- WAW plus simultaneous set/clear: x3 busy; new instruction rd=x3 with wb rd=x3 in the same cycle → issues, and xbusy[3]=1 afterwards.
- Serialise: x4 and f2 busy; dec_serial_i=1 → state DRAIN, sb_rdy_o=0 until both writebacks complete, then issues. stall_cnt_o equals the drain cycle count.
- Flush: x9 busy and stalled instruction rs1=x9; flush_i pulse → sb_rdy_o=0 that cycle, next cycle all busy clear, state RUN, instruction issues.
